// File: rtl/uart_status_reporter.sv
// Telemetry side of the UART command link: snapshots the PWM step divider, converts it to
// decimal and streams the frame "D=ddddd\r\n" into uart_tx over its en/busy handshake.
//
// state   | meaning
// IDLE    | waiting for a request, a pending request or a divider change
// CONVERT | 16 double-dabble iterations on the snapshot
// SEND    | register frame[idx] and strobe tx_en
// GAP     | one cycle while uart_tx raises busy
// WAIT    | hold until uart_tx is free, then next byte or finish
// DONE    | frame_done pulse
module uart_status_reporter #(
  parameter bit          AUTO_REPORT = 1'b1,
  parameter logic [7:0]  TAG_CHAR    = 8'h44
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        report_req,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, CONVERT, SEND, GAP, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] snap;
  logic [15:0] last_reported;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [3:0]  bit_cnt;
  logic [3:0]  idx;
  logic        pending;
  logic        trigger;
  logic [7:0]  frame_byte;

  assign trigger = report_req | pending | (AUTO_REPORT & (value_in != last_reported));

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    case (state)
      IDLE:    if (trigger) state_nx = CONVERT;
      CONVERT: if (bit_cnt == 4'd0) state_nx = SEND;
      SEND:    state_nx = GAP;
      GAP:     state_nx = WAIT;
      WAIT:    if (!tx_busy) state_nx = (idx == 4'd8) ? DONE : SEND;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // add-3 correction applied before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    case (idx)
      4'd0:    frame_byte = TAG_CHAR;
      4'd1:    frame_byte = 8'h3D;
      4'd2:    frame_byte = 8'h30 + {4'h0, bcd[19:16]};
      4'd3:    frame_byte = 8'h30 + {4'h0, bcd[15:12]};
      4'd4:    frame_byte = 8'h30 + {4'h0, bcd[11:8]};
      4'd5:    frame_byte = 8'h30 + {4'h0, bcd[7:4]};
      4'd6:    frame_byte = 8'h30 + {4'h0, bcd[3:0]};
      4'd7:    frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      snap          <= 16'h0000;
      last_reported <= 16'h0000;
      bcd           <= 20'h00000;
      bit_cnt       <= 4'd0;
      idx           <= 4'd0;
      pending       <= 1'b0;
      tx_data       <= 8'h00;
      tx_en         <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      if (state != IDLE && report_req) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (trigger) begin
            snap          <= value_in;
            last_reported <= value_in;
            pending       <= 1'b0;
            bcd           <= 20'h00000;
            bit_cnt       <= 4'd15;
          end
        end
        CONVERT: begin
          bcd     <= {bcd_adj[18:0], snap[15]};
          snap    <= {snap[14:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd0) idx <= 4'd0;
        end
        SEND: begin
          tx_data <= frame_byte;
          tx_en   <= 1'b1;
        end
        WAIT: begin
          if (!tx_busy && idx != 4'd8) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_reporter.sv
// Bench for uart_status_reporter: a uart_tx busy model collects bytes, and expected frames
// come from decimal arithmetic on the reported value.
module tb_uart_status_reporter;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic        report_req = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        busy;
  logic        frame_done;

  always #5 clk1 = ~clk1;

  uart_status_reporter dut (
    .clk1       (clk1),
    .rst        (rst),
    .value_in   (value_in),
    .report_req (report_req),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] got_q[$];
  int         done_cnt = 0;
  int         en_total = 0;
  int         viol = 0;
  int         busy_len = 10;
  bit         force_busy = 1'b0;
  bit         prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int v, input int i);
    int p10[5];
    int d;
    p10 = '{10000, 1000, 100, 10, 1};
    case (i)
      0:       return 8'h44;
      1:       return 8'h3D;
      7:       return 8'h0D;
      8:       return 8'h0A;
      default: begin
        d = (v / p10[i-2]) % 10;
        return 8'h30 + d[7:0];
      end
    endcase
  endfunction

  // Monitor and uart_tx model: busy rises the cycle after tx_en and lasts busy_len cycles.
  initial begin
    int busy_cnt;
    bit en_s;
    busy_cnt = 0;
    forever begin
      @(negedge clk1);
      en_s = tx_en;
      if (tx_en) begin
        got_q.push_back(tx_data);
        en_total++;
        if (tx_busy || prev_en) viol++;
      end
      prev_en = tx_en;
      if (frame_done) done_cnt++;
      @(posedge clk1);
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (en_s) busy_cnt = busy_len;
      tx_busy = force_busy || (busy_cnt != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk1);
    #1;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, done_cnt, target);
    repeat (3) tick();
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, (got_q.size() >= n), 1);
  endtask

  task automatic check_frame(input string tag, input int v);
    logic [7:0] b;
    for (int i = 0; i < 9; i++) begin
      if (got_q.size() == 0) b = 8'hEE;
      else b = got_q.pop_front();
      chk($sformatf("%s_b%0d", tag, i), b, exp_byte(v, i));
    end
  endtask

  initial begin
    int base, k, e0, v, tb_last;
    repeat (3) tick();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // value 0 equals the cleared last value: nothing starts on its own
    repeat (30) tick();
    chk("idle_no_frame", got_q.size(), 0);
    chk("idle_busy", busy, 0);

    base = done_cnt;
    pulse_req();
    wait_done("t0_done", base + 1, 2000);
    check_frame("t0", 0);

    // request and value change in the same cycle give one frame
    base = done_cnt;
    value_in = 16'd1600;
    pulse_req();
    wait_done("t1_done", base + 1, 2000);
    check_frame("t1", 1600);
    repeat (50) tick();
    chk("t1_single", done_cnt, base + 1);

    base = done_cnt;
    value_in = 16'd65535;
    wait_done("t2_done", base + 1, 2000);
    check_frame("t2", 65535);

    // latency: first tx_en in the cycle after edge N+17
    base = done_cnt;
    report_req = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
      report_req = 1'b0;
    end while (!tx_en && k < 40);
    chk("latency", k, 18);
    wait_bytes("stall_first", 1, 50);
    force_busy = 1'b1;
    e0 = en_total;
    repeat (1000) tick();
    chk("stall_no_en", en_total, e0);
    chk("stall_busy", busy, 1);
    chk("stall_tx_en", tx_en, 0);
    force_busy = 1'b0;
    wait_done("stall_done", base + 1, 2000);
    check_frame("t6", 65535);

    // value change mid-frame: one more frame with the new value, no third
    base = done_cnt;
    value_in = 16'd825;
    wait_bytes("t3_mid", 3, 200);
    value_in = 16'd556;
    wait_done("t3_done", base + 2, 4000);
    check_frame("t3a", 825);
    check_frame("t3b", 556);
    repeat (200) tick();
    chk("t3_no_third", done_cnt, base + 2);
    chk("t3_no_bytes", got_q.size(), 0);

    // three requests during one frame coalesce into one extra frame
    base = done_cnt;
    pulse_req();
    wait_bytes("t4_mid", 2, 200);
    repeat (3) begin
      pulse_req();
      repeat (5) tick();
    end
    wait_done("t4_done", base + 2, 4000);
    check_frame("t4a", 556);
    check_frame("t4b", 556);
    repeat (200) tick();
    chk("t4_no_third", done_cnt, base + 2);

    // reset after the 4th byte abandons the frame; auto-report restarts afterwards
    base = done_cnt;
    value_in = 16'd4321;
    wait_bytes("t5_four", 4, 500);
    rst = 1'b1;
    e0 = en_total;
    tick();
    chk("t5_tx_en", tx_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_data", tx_data, 0);
    chk("t5_done", frame_done, 0);
    repeat (3) tick();
    chk("t5_no_en", en_total, e0);
    chk("t5_no_done", done_cnt, base);
    got_q.delete();
    rst = 1'b0;
    wait_done("t5_restart", base + 1, 2000);
    check_frame("t5", 4321);
    tb_last = 4321;

    for (int it = 0; it < 8; it++) begin
      v = $urandom_range(0, 65535);
      busy_len = $urandom_range(1, 12);
      base = done_cnt;
      value_in = v[15:0];
      if (v == tb_last || $urandom_range(0, 1) == 1) pulse_req();
      wait_done($sformatf("rnd%0d_done", it), base + 1, 2500);
      check_frame($sformatf("rnd%0d", it), v);
      tb_last = v;
    end

    chk("tx_en_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
